// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST engine: FSM state encoding and the
// default 64-bit Galois feedback mask.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } bist_state_e;

  localparam logic [63:0] DEFAULT_POLY_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/bist_misr_lane.sv
// One MISR signature lane: seeded by load, compacts one DUT result word per
// update, and flags whether the signature it is about to hold matches golden.
module bist_misr_lane #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] POLY       = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load,
  input  logic                  update,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] golden,
  output logic [DATA_WIDTH-1:0] sig,
  output logic                  match
);

  logic [DATA_WIDTH-1:0] sig_nxt;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sig_nxt = sig;
    if (load) begin
      sig_nxt = seed;
    end else if (update) begin
      sig_nxt = ((sig >> 1) ^ (sig[0] ? POLY : '0)) ^ data;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sig <= '0;
    end else begin
      sig <= sig_nxt;
    end
  end

  // Compare against the next value so a result taken on the last DRAIN edge
  // includes that edge's update.
  assign match = (sig_nxt == golden);

endmodule

// File: rtl/bist_engine.sv
// BIST engine: LFSR pattern source, NUM_CH MISR lanes and the FSM that runs
// seed load, pattern issue, pipeline drain and golden compare.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    NUM_CH       = 2,
  parameter int                    CNT_WIDTH    = 16,
  parameter int                    DRAIN_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0] POLY         = DEFAULT_POLY_64[DATA_WIDTH-1:0]
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         en_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic [DATA_WIDTH-1:0]        seed_i,
  input  logic [CNT_WIDTH-1:0]         num_patterns_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] golden_i,
  output logic                         pat_valid_o,
  output logic [DATA_WIDTH-1:0]        pat_data_o,
  input  logic [NUM_CH-1:0]            dut_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dut_data_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] sig_o,
  output logic [CNT_WIDTH-1:0]         pat_cnt_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_CH-1:0]            pass_o
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  bist_state_e           state;
  logic                  start_q;
  logic                  start_edge;
  logic [DATA_WIDTH-1:0] lfsr;
  logic [CNT_WIDTH-1:0]  pat_cnt;
  logic [CNT_WIDTH-1:0]  num_pat;
  logic [DCW-1:0]        drain_cnt;
  logic [NUM_CH-1:0]     lane_match;
  logic                  lane_load;
  logic                  lane_live;

  assign start_edge = start_i & ~start_q;
  assign pat_data_o = lfsr;
  assign pat_cnt_o  = pat_cnt;

  function automatic logic [DATA_WIDTH-1:0] step(input logic [DATA_WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      lfsr        <= '0;
      pat_cnt     <= '0;
      num_pat     <= '0;
      drain_cnt   <= '0;
      pat_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= '0;
    end else if (en_i) begin
      start_q <= start_i;
      if (abort_i) begin
        // Signatures and pattern count are left in place for post-mortem reads.
        state       <= IDLE;
        pat_valid_o <= 1'b0;
        busy_o      <= 1'b0;
        done_o      <= 1'b0;
        pass_o      <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_edge) begin
              state  <= LOAD;
              busy_o <= 1'b1;
            end
          end
          LOAD: begin
            lfsr      <= (seed_i == '0) ? DATA_WIDTH'(1) : seed_i;
            pat_cnt   <= '0;
            num_pat   <= num_patterns_i;
            drain_cnt <= '0;
            if (num_patterns_i != '0) begin
              state       <= RUN;
              pat_valid_o <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
          RUN: begin
            lfsr    <= step(lfsr);
            pat_cnt <= pat_cnt + CNT_WIDTH'(1);
            if (pat_cnt == num_pat - CNT_WIDTH'(1)) begin
              state       <= DRAIN;
              pat_valid_o <= 1'b0;
            end
          end
          DRAIN: begin
            if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              pass_o <= lane_match;
            end else begin
              drain_cnt <= drain_cnt + DCW'(1);
            end
          end
          DONE: begin
            if (start_edge) begin
              state  <= LOAD;
              busy_o <= 1'b1;
              done_o <= 1'b0;
              pass_o <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign lane_load = en_i & ~abort_i & (state == LOAD);
  assign lane_live = en_i & ~abort_i & ((state == RUN) || (state == DRAIN));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    bist_misr_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .POLY      (POLY)
    ) u_lane (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .load  (lane_load),
      .update(lane_live & dut_valid_i[c]),
      .seed  (seed_i),
      .data  (dut_data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .golden(golden_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .sig   (sig_o[c*DATA_WIDTH +: DATA_WIDTH]),
      .match (lane_match[c])
    );
  end

endmodule

// File: tb/tb_bist_engine.sv
// Directed bench for bist_engine (8-bit, two lanes, POLY B8, drain 2) with a
// one-cycle loopback DUT model feeding pat_data back into both MISR lanes.
module tb_bist_engine;

  localparam int DW = 8;
  localparam int NCH = 2;
  localparam int CW = 16;
  localparam int DRAIN = 2;

  typedef struct {
    logic [7:0]  seed;
    logic [15:0] n;
    logic [7:0]  g0;
    logic [7:0]  g1;
    logic [7:0]  exp_sig;
    logic [1:0]  exp_pass;
  } vec_t;

  logic             clk = 1'b0;
  logic             rstn_i = 1'b0;
  logic             en_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [DW-1:0]    seed_i = '0;
  logic [CW-1:0]    num_patterns_i = '0;
  logic [NCH*DW-1:0] golden_i = '0;
  logic             pat_valid_o;
  logic [DW-1:0]    pat_data_o;
  logic [NCH-1:0]   dut_valid_i;
  logic [NCH*DW-1:0] dut_data_i;
  logic [NCH*DW-1:0] sig_o;
  logic [CW-1:0]    pat_cnt_o;
  logic             busy_o;
  logic             done_o;
  logic [NCH-1:0]   pass_o;

  logic             lb_valid = 1'b0;
  logic [DW-1:0]    lb_data = '0;

  int tests = 0;
  int fails = 0;
  vec_t vecs [4];

  bist_engine #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NCH),
    .CNT_WIDTH   (CW),
    .DRAIN_CYCLES(DRAIN),
    .POLY        (8'hB8)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .en_i          (en_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .seed_i        (seed_i),
    .num_patterns_i(num_patterns_i),
    .golden_i      (golden_i),
    .pat_valid_o   (pat_valid_o),
    .pat_data_o    (pat_data_o),
    .dut_valid_i   (dut_valid_i),
    .dut_data_i    (dut_data_i),
    .sig_o         (sig_o),
    .pat_cnt_o     (pat_cnt_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_o        (pass_o)
  );

  always #5 clk = ~clk;

  // Loopback DUT: one-cycle pipeline that stalls with the engine's enable.
  always @(posedge clk) begin
    if (en_i) begin
      lb_valid <= pat_valid_o;
      lb_data  <= pat_data_o;
    end
  end
  assign dut_valid_i = {NCH{lb_valid}};
  assign dut_data_i  = {NCH{lb_data}};

  function automatic logic [7:0] tb_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run with pattern, latency and signature checks; optional en_i stall
  // of four cycles after enabled edge hold_at, optional start_i left high.
  task automatic run(input vec_t v, input int hold_at, input bit keep_start);
    logic [7:0]  exp_lfsr;
    logic [7:0]  frz_data;
    logic [15:0] frz_cnt;
    int k = 0;
    int npat = 0;
    int hold_cnt = 0;
    bit got_done = 1'b0;
    seed_i         = v.seed;
    num_patterns_i = v.n;
    golden_i       = {v.g1, v.g0};
    exp_lfsr       = (v.seed == 8'h00) ? 8'h01 : v.seed;
    frz_data       = '0;
    frz_cnt        = '0;
    start_i        = 1'b1;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      tick();
      if (!keep_start) start_i = 1'b0;
      if (!en_i) begin
        check("hold_data", 64'(pat_data_o), 64'(frz_data));
        check("hold_cnt", 64'(pat_cnt_o), 64'(frz_cnt));
        hold_cnt++;
        if (hold_cnt == 4) en_i = 1'b1;
        continue;
      end
      k++;
      if (pat_valid_o) begin
        check("pattern", 64'(pat_data_o), 64'(exp_lfsr));
        exp_lfsr = tb_step(exp_lfsr);
        npat++;
      end
      if (k == 2 && v.n != 16'd0) check("first_cnt", 64'(pat_cnt_o), 64'd0);
      if (done_o) begin
        got_done = 1'b1;
        check("done_latency", 64'(k), 64'(int'(v.n) + 2 + DRAIN));
        check("num_issued", 64'(npat), 64'(v.n));
        check("final_cnt", 64'(pat_cnt_o), 64'(v.n));
        check("sig", 64'(sig_o), 64'({v.exp_sig, v.exp_sig}));
        check("pass", 64'(pass_o), 64'(v.exp_pass));
        check("busy_done", 64'(busy_o), 64'd0);
      end
      if (k == hold_at && hold_cnt == 0) begin
        en_i     = 1'b0;
        frz_data = pat_data_o;
        frz_cnt  = pat_cnt_o;
      end
    end
    if (!got_done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    // seed, N, golden0, golden1, final signature, pass
    vecs[0] = '{8'h01, 16'd5, 8'hA4, 8'hA5, 8'hA4, 2'b01};
    vecs[1] = '{8'h00, 16'd2, 8'h00, 8'h00, 8'h00, 2'b11};
    vecs[2] = '{8'h5A, 16'd0, 8'h00, 8'h5A, 8'h5A, 2'b10};
    vecs[3] = '{8'h80, 16'd3, 8'h30, 8'h30, 8'h30, 2'b11};

    repeat (2) tick();
    check("rst_valid", 64'(pat_valid_o), 64'd0);
    check("rst_data", 64'(pat_data_o), 64'd0);
    check("rst_sig", 64'(sig_o), 64'd0);
    check("rst_cnt", 64'(pat_cnt_o), 64'd0);
    check("rst_flags", 64'({busy_o, done_o, pass_o}), 64'd0);
    rstn_i = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run(vecs[i], 0, 1'b0);
      tick();
      check("done_hold", 64'(done_o), 64'd1);
    end

    // Abort beats start while sitting in DONE.
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("abort_prio_busy", 64'(busy_o), 64'd0);
    check("abort_prio_done", 64'(done_o), 64'd0);
    tick();

    // Abort on the third RUN cycle.
    seed_i         = 8'h01;
    num_patterns_i = 16'd5;
    start_i        = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      start_i = 1'b0;
    end
    check("abort_pre_cnt", 64'(pat_cnt_o), 64'd2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_done", 64'(done_o), 64'd0);
    check("abort_valid", 64'(pat_valid_o), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_cnt", 64'(pat_cnt_o), 64'd2);
    check("abort_sig", 64'(sig_o), 64'h0000_0000_0000_B9B9);
    tick();
    run(vecs[0], 0, 1'b0);
    tick();

    // Four-cycle enable stall mid-RUN must not disturb the run.
    run(vecs[0], 3, 1'b0);
    tick();

    // start_i held high through DONE: no relaunch until it toggles.
    run(vecs[3], 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("start_held_done", 64'({done_o, busy_o}), 64'b10);
    end
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
    tick();
    check("restart_busy", 64'({done_o, busy_o}), 64'b01);
    start_i = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        tick();
        seen = done_o;
      end
      check("restart_done", 64'(seen), 64'd1);
      check("restart_sig", 64'(sig_o), 64'h0000_0000_0000_3030);
    end
    tick();

    // Asynchronous reset in the middle of a run.
    seed_i         = 8'h01;
    num_patterns_i = 16'd5;
    start_i        = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start_i = 1'b0;
    end
    #2 rstn_i = 1'b0;
    #1;
    check("arst_sig", 64'(sig_o), 64'd0);
    check("arst_flags", 64'({pat_valid_o, busy_o, done_o}), 64'd0);
    check("arst_cnt", 64'(pat_cnt_o), 64'd0);
    #3 rstn_i = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
